mem_access_unit: RTL

//  In-order load/store front end for data_mem. Accepts tagged load/store requests from the core
//  (valid/ready), drives the data_mem ports, and returns load data with its tag through a

---
 rtl/mem_access_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// In-order load/store front end for data_mem. S1 drives the RAM ports and S2 samples the read
// data. A credit-protected queue absorbs back-pressure so the pipe itself never stalls.
module mem_access_unit #(
  parameter int DATA_MEM_WIDTH = 10,
  parameter int TAG_WIDTH      = 6,
  parameter int RESP_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [31:0]               req_addr,
  input  logic [31:0]               req_wdata,
  input  logic [TAG_WIDTH-1:0]      req_tag,
  output logic [DATA_MEM_WIDTH-1:0] mem_addra,
  output logic [DATA_MEM_WIDTH-1:0] mem_addrb,
  output logic [31:0]               mem_dina,
  output logic                      mem_wea,
  input  logic [31:0]               mem_doutb,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [31:0]               resp_data,
  output logic [TAG_WIDTH-1:0]      resp_tag,
  output logic                      resp_err
);
  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;

  logic                      req_err;
  logic                      accept;
  logic                      credit_ok;
  logic [SW-1:0]             pending;

  logic                      s1_valid;
  logic                      s1_we;
  logic                      s1_err;
  logic                      s1_resp;
  logic [DATA_MEM_WIDTH-1:0] s1_addr;
  logic [31:0]               s1_wdata;
  logic [TAG_WIDTH-1:0]      s1_tag;

  logic                      s2_valid;
  logic                      s2_err;
  logic [TAG_WIDTH-1:0]      s2_tag;
  logic [31:0]               s2_data;

  logic [31:0]               q_data [RESP_DEPTH];
  logic [TAG_WIDTH-1:0]      q_tag  [RESP_DEPTH];
  logic                      q_err  [RESP_DEPTH];
  logic [PW-1:0]             wr_ptr;
  logic [PW-1:0]             rd_ptr;
  logic [CW-1:0]             q_count;
  logic                      q_empty;
  logic                      push;
  logic                      pop;

  assign req_err = |req_addr[31:DATA_MEM_WIDTH];
  assign s1_resp = s1_valid & (~s1_we | s1_err);

  // Everything that will still produce a response counts against the credit, including S2
  // in a fall-through cycle; this is conservative but keeps the queue from ever overflowing.
  assign pending   = SW'(s1_resp) + SW'(s2_valid) + SW'(q_count);
  assign credit_ok = pending < SW'(RESP_DEPTH);
  assign req_ready = ~reset & (credit_ok | (req_we & ~req_err));
  assign accept    = req_valid & req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_we    <= 1'b0;
      s1_err   <= 1'b0;
      s1_addr  <= '0;
      s1_wdata <= '0;
      s1_tag   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_we    <= req_we;
        s1_err   <= req_err;
        s1_addr  <= req_addr[DATA_MEM_WIDTH-1:0];
        s1_wdata <= req_wdata;
        s1_tag   <= req_tag;
      end
    end
  end

  assign mem_addra = s1_addr;
  assign mem_addrb = s1_addr;
  assign mem_dina  = s1_wdata;
  assign mem_wea   = s1_valid & s1_we & ~s1_err;

  // S2 only carries requests that owe a response; clean stores retire out of S1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_err   <= 1'b0;
      s2_tag   <= '0;
    end else begin
      s2_valid <= s1_resp;
      s2_err   <= s1_err;
      s2_tag   <= s1_tag;
    end
  end

  assign s2_data = s2_err ? '0 : mem_doutb;

  assign q_empty = (q_count == '0);
  assign push    = s2_valid & ~(q_empty & resp_ready);
  assign pop     = ~q_empty & resp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      q_count <= q_count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= s2_data;
      q_tag[wr_ptr]  <= s2_tag;
      q_err[wr_ptr]  <= s2_err;
    end
  end

  always_comb begin
    resp_valid = s2_valid;
    resp_data  = s2_data;
    resp_tag   = s2_tag;
    resp_err   = s2_err;
    if (!q_empty) begin
      resp_valid = 1'b1;
      resp_data  = q_data[rd_ptr];
      resp_tag   = q_tag[rd_ptr];
      resp_err   = q_err[rd_ptr];
    end
  end

endmodule
